// File: rtl/ifu_pkg.sv
// Shared types for the decode stage: instruction classes, RV32I opcodes and
// the decoded-instruction record carried through the skid buffer.
package ifu_pkg;

  localparam int unsigned Xlen = 32;

  typedef enum logic [2:0] {
    ClsAluR   = 3'd0,
    ClsAluI   = 3'd1,
    ClsLoad   = 3'd2,
    ClsStore  = 3'd3,
    ClsBranch = 3'd4,
    ClsJal    = 3'd5,
    ClsJalr   = 3'd6,
    ClsOther  = 3'd7
  } dec_class_e;

  localparam logic [6:0] OpAluR   = 7'b0110011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [Xlen-1:0] imm;
    dec_class_e      iclass;
    logic            illegal;
    logic [Xlen-1:0] jump_target;
  } decoded_instr_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I field/immediate/class decoder.
module rv32i_decoder
  import ifu_pkg::*;
(
  input  logic [31:0]    instruction,
  input  logic [31:0]    pc,
  output decoded_instr_t decoded
);

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction[6:0];
  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u  = {instruction[31:12], 12'b0};
  assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    decoded             = '0;
    decoded.pc          = pc;
    decoded.rd          = instruction[11:7];
    decoded.rs1         = instruction[19:15];
    decoded.rs2         = instruction[24:20];
    decoded.funct3      = instruction[14:12];
    decoded.funct7      = instruction[31:25];
    decoded.iclass      = ClsOther;
    decoded.illegal     = 1'b0;
    decoded.imm         = '0;
    // Opcodes with bits [1:0] != 2'b11 never match a listed value.
    case (opcode)
      OpAluR:   decoded.iclass = ClsAluR;
      OpAluI:   begin decoded.iclass = ClsAluI;   decoded.imm = imm_i; end
      OpLoad:   begin decoded.iclass = ClsLoad;   decoded.imm = imm_i; end
      OpStore:  begin decoded.iclass = ClsStore;  decoded.imm = imm_s; end
      OpBranch: begin decoded.iclass = ClsBranch; decoded.imm = imm_b; end
      OpJal:    begin decoded.iclass = ClsJal;    decoded.imm = imm_j; end
      OpJalr:   begin decoded.iclass = ClsJalr;   decoded.imm = imm_i; end
      OpLui, OpAuipc:    decoded.imm = imm_u;
      OpSystem, OpFence: decoded.imm = imm_i;
      default:  decoded.illegal = 1'b1;
    endcase
    decoded.jump_target = '0;
    if (decoded.iclass == ClsBranch || decoded.iclass == ClsJal) begin
      decoded.jump_target = pc + decoded.imm;
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Decode stage: registered decode result behind a two-entry skid buffer
// (output register + skid register) with flush and a transfer counter.
module instruction_decode_stage
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  instruction,
  input  logic [XLEN-1:0]  instruction_pc,
  input  logic             instruction_valid,
  output logic             fetch_next,
  input  logic             flush,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [XLEN-1:0]  dec_pc,
  output logic [4:0]       dec_rd,
  output logic [4:0]       dec_rs1,
  output logic [4:0]       dec_rs2,
  output logic [2:0]       dec_funct3,
  output logic [6:0]       dec_funct7,
  output logic [XLEN-1:0]  dec_imm,
  output logic [2:0]       dec_class,
  output logic             dec_illegal,
  output logic [XLEN-1:0]  dec_jump_target,
  output logic [CNT_W-1:0] decoded_count
);

  decoded_instr_t decoded;
  decoded_instr_t out_q, out_d, skid_q, skid_d;
  logic           out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic           fetch_next_q;
  logic [CNT_W-1:0] count_q;
  logic           accept, xfer;

  rv32i_decoder u_decoder (
    .instruction (instruction),
    .pc          (instruction_pc),
    .decoded     (decoded)
  );

  assign accept = instruction_valid && fetch_next_q && !flush;
  assign xfer   = out_valid_q && dec_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || xfer) begin
      // Output slot frees up: the older skid entry goes first to keep order.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = decoded;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = decoded;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = decoded;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      fetch_next_q <= 1'b1;
      count_q      <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      fetch_next_q <= !skid_valid_d;
      if (xfer && !flush) count_q <= count_q + CNT_W'(1);
    end
  end

  assign fetch_next      = fetch_next_q;
  assign dec_valid       = out_valid_q;
  assign dec_pc          = out_q.pc;
  assign dec_rd          = out_q.rd;
  assign dec_rs1         = out_q.rs1;
  assign dec_rs2         = out_q.rs2;
  assign dec_funct3      = out_q.funct3;
  assign dec_funct7      = out_q.funct7;
  assign dec_imm         = out_q.imm;
  assign dec_class       = out_q.iclass;
  assign dec_illegal     = out_q.illegal;
  assign dec_jump_target = out_q.jump_target;
  assign decoded_count   = count_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: expected decodes are queued on
// accept and compared in order on each output transfer.
module tb_instruction_decode_stage;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm, tgt;
    logic        ill;
  } exp_t;

  logic        clk, rst, instruction_valid, fetch_next, flush, dec_valid, dec_ready;
  logic [31:0] instruction, instruction_pc, dec_pc, dec_imm, dec_jump_target, decoded_count;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  dec_funct3, dec_class;
  logic [6:0]  dec_funct7;
  logic        dec_illegal;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  exp_t        cur_exp;
  logic [31:0] exp_count = 0;
  logic        stall_q = 0;
  logic [31:0] stall_pc = 0;

  instruction_decode_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid), .fetch_next(fetch_next), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
    .dec_imm(dec_imm), .dec_class(dec_class), .dec_illegal(dec_illegal),
    .dec_jump_target(dec_jump_target), .decoded_count(decoded_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic exp_t mk(logic [31:0] pc, logic [2:0] cls, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                              logic [31:0] tgt, logic ill);
    exp_t e;
    e.pc = pc; e.cls = cls; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.f3 = f3; e.f7 = f7; e.imm = imm; e.tgt = tgt; e.ill = ill;
    return e;
  endfunction

  // Monitor: samples mid-cycle, so inputs and registered outputs are stable.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      sb.delete();
      stall_q = 0;
      if (rst) exp_count = 0;
    end else begin
      if (stall_q && dec_valid) begin
        checks++;
        if (dec_pc !== stall_pc) begin
          errors++;
          $display("FAIL stall_stable: dec_pc=%h, required %h", dec_pc, stall_pc);
        end
      end
      if (dec_valid && dec_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: output pc=%h, required no output", dec_pc);
        end else begin
          e = sb.pop_front();
          if (dec_pc !== e.pc || dec_class !== e.cls || dec_rd !== e.rd || dec_rs1 !== e.rs1 ||
              dec_rs2 !== e.rs2 || dec_funct3 !== e.f3 || dec_funct7 !== e.f7 ||
              dec_imm !== e.imm || dec_jump_target !== e.tgt || dec_illegal !== e.ill) begin
            errors++;
            $display("FAIL sb_out: got pc=%h cls=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h tgt=%h ill=%b; required pc=%h cls=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h tgt=%h ill=%b",
                     dec_pc, dec_class, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7,
                     dec_imm, dec_jump_target, dec_illegal, e.pc, e.cls, e.rd, e.rs1, e.rs2,
                     e.f3, e.f7, e.imm, e.tgt, e.ill);
          end
        end
        checks++;
        if (decoded_count !== exp_count) begin
          errors++;
          $display("FAIL sb_count: decoded_count=%0d, required %0d", decoded_count, exp_count);
        end
        exp_count = exp_count + 1;
      end
      stall_q  = dec_valid && !dec_ready;
      stall_pc = dec_pc;
      if (instruction_valid && fetch_next) sb.push_back(cur_exp);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] w, input exp_t e);
    instruction = w; instruction_pc = e.pc; instruction_valid = 1; cur_exp = e;
  endtask

  task automatic idle;
    instruction_valid = 0;
  endtask

  // Hold the word until it is accepted; returns just after the accepting edge.
  task automatic present(input logic [31:0] w, input exp_t e);
    logic acc;
    int   n;
    set_in(w, e);
    n = 0;
    do begin
      @(negedge clk);
      acc = fetch_next;
      tick();
      n++;
    end while (!acc && n < 50);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: pc=%h not accepted after %0d cycles, required accept", e.pc, n);
    end
  endtask

  task automatic test_reset;
    rst = 1; flush = 0; dec_ready = 0; idle(); instruction = 0; instruction_pc = 0;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({dec_valid, fetch_next, decoded_count, dec_pc, dec_imm, dec_class} !== {1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: valid=%b fetch_next=%b count=%0d pc=%h imm=%h cls=%0d, required 0 1 0 0 0 0",
               dec_valid, fetch_next, decoded_count, dec_pc, dec_imm, dec_class);
    end
    tick();
  endtask

  task automatic test_addi;
    dec_ready = 1;
    present(32'h00500093, mk(32'h0, 3'd1, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 32'h0, 1'b0));
    idle();
    @(negedge clk);
    checks++;
    if ({dec_valid, dec_class, dec_rd, dec_rs1, dec_imm} !== {1'b1, 3'd1, 5'd1, 5'd0, 32'h5}) begin
      errors++;
      $display("FAIL addi: valid=%b cls=%0d rd=%0d rs1=%0d imm=%h, required 1 1 1 0 00000005",
               dec_valid, dec_class, dec_rd, dec_rs1, dec_imm);
    end
    tick();
    @(negedge clk);
    checks++;
    if (decoded_count !== 32'd1 || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_count: count=%0d valid=%b, required 1 0", decoded_count, dec_valid);
    end
    tick();
  endtask

  task automatic test_jump_branch;
    dec_ready = 1;
    present(32'h0080006F, mk(32'h20, 3'd5, 5'd0, 5'd0, 5'd8, 3'd0, 7'h00, 32'h8, 32'h28, 1'b0));
    idle();
    @(negedge clk);
    checks++;
    if ({dec_class, dec_rd, dec_imm, dec_jump_target} !== {3'd5, 5'd0, 32'h8, 32'h28}) begin
      errors++;
      $display("FAIL jal: cls=%0d rd=%0d imm=%h tgt=%h, required 5 0 00000008 00000028",
               dec_class, dec_rd, dec_imm, dec_jump_target);
    end
    tick();
    present(32'hFE208EE3, mk(32'h100, 3'd4, 5'd29, 5'd1, 5'd2, 3'd0, 7'h7f, 32'hFFFFFFFC,
                             32'hFC, 1'b0));
    idle();
    @(negedge clk);
    checks++;
    if ({dec_class, dec_rs1, dec_rs2, dec_imm, dec_jump_target} !==
        {3'd4, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFC}) begin
      errors++;
      $display("FAIL beq: cls=%0d rs1=%0d rs2=%0d imm=%h tgt=%h, required 4 1 2 fffffffc 000000fc",
               dec_class, dec_rs1, dec_rs2, dec_imm, dec_jump_target);
    end
    tick();
  endtask

  task automatic test_illegal;
    dec_ready = 1;
    present(32'hFFFFFFFF, mk(32'h40, 3'd7, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7f, 32'h0, 32'h0, 1'b1));
    idle();
    @(negedge clk);
    checks++;
    if ({dec_illegal, dec_class, dec_imm, dec_rd, dec_funct7} !== {1'b1, 3'd7, 32'h0, 5'd31, 7'h7f}) begin
      errors++;
      $display("FAIL illegal: ill=%b cls=%0d imm=%h rd=%0d f7=%h, required 1 7 00000000 31 7f",
               dec_illegal, dec_class, dec_imm, dec_rd, dec_funct7);
    end
    tick();
    present(32'h0000007B, mk(32'h44, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h0, 1'b1));
    idle();
    @(negedge clk);
    checks++;
    if (dec_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_unlisted: ill=%b, required 1", dec_illegal);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] c0;
    dec_ready = 1;
    c0 = exp_count;
    present(32'h123450B7, mk(32'h60, 3'd7, 5'd1, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000, 32'h0, 1'b0));
    present(32'h0020A423, mk(32'h64, 3'd3, 5'd8, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8, 32'h0, 1'b0));
    present(32'hFFC0A283, mk(32'h68, 3'd2, 5'd5, 5'd1, 5'd28, 3'd2, 7'h7f, 32'hFFFFFFFC, 32'h0,
                             1'b0));
    present(32'h402081B3, mk(32'h6C, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 32'h0, 1'b0));
    present(32'h00008067, mk(32'h70, 3'd6, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h0, 32'h0, 1'b0));
    idle();
    tick(); tick();
    @(negedge clk);
    checks++;
    if (decoded_count !== c0 + 32'd5 || sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: count=%0d pending=%0d, required %0d 0",
               decoded_count, sb.size(), c0 + 32'd5);
    end
    tick();
  endtask

  task automatic test_backpressure;
    exp_t e;
    e = mk(32'h0, 3'd1, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 32'h0, 1'b0);
    dec_ready = 0;
    present(32'h00500093, e);
    e.pc = 32'h4;
    present(32'h00500093, e);
    e.pc = 32'h8;
    set_in(32'h00500093, e);
    @(negedge clk);
    checks++;
    if ({fetch_next, dec_valid, dec_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bp_full: fetch_next=%b valid=%b pc=%h, required 0 1 00000000",
               fetch_next, dec_valid, dec_pc);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({fetch_next, dec_pc} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL bp_hold: fetch_next=%b pc=%h, required 0 00000000", fetch_next, dec_pc);
    end
    tick();
    dec_ready = 1;
    @(negedge clk);
    checks++;
    if (dec_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_drain0: pc=%h, required 00000000", dec_pc);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({dec_valid, dec_pc, fetch_next} !== {1'b1, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL bp_drain4: valid=%b pc=%h fetch_next=%b, required 1 00000004 1",
               dec_valid, dec_pc, fetch_next);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({dec_valid, dec_pc} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL bp_drain8: valid=%b pc=%h, required 1 00000008", dec_valid, dec_pc);
    end
    tick();
  endtask

  task automatic test_flush;
    exp_t        e;
    logic [31:0] c;
    e = mk(32'h300, 3'd1, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 32'h0, 1'b0);
    dec_ready = 0;
    present(32'h00500093, e);
    e.pc = 32'h304;
    present(32'h00500093, e);
    e.pc = 32'h308;
    set_in(32'h00500093, e);
    c = exp_count;
    flush = 1; dec_ready = 1;
    tick();
    flush = 0; idle();
    @(negedge clk);
    checks++;
    if ({dec_valid, fetch_next, decoded_count} !== {1'b0, 1'b1, c}) begin
      errors++;
      $display("FAIL flush: valid=%b fetch_next=%b count=%0d, required 0 1 %0d",
               dec_valid, fetch_next, decoded_count, c);
    end
    tick();
    e.pc = 32'h200;
    present(32'h00500093, e);
    idle();
    @(negedge clk);
    checks++;
    if ({dec_valid, dec_pc} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL flush_next: valid=%b pc=%h, required 1 00000200", dec_valid, dec_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    exp_t e;
    e = mk(32'h400, 3'd1, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'h5, 32'h0, 1'b0);
    dec_ready = 0;
    present(32'h00500093, e);
    e.pc = 32'h404;
    present(32'h00500093, e);
    idle();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({dec_valid, fetch_next, decoded_count, dec_pc, dec_imm, dec_class, dec_rd, dec_rs2} !==
        {1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_mid: valid=%b fetch_next=%b count=%0d pc=%h imm=%h cls=%0d rd=%0d rs2=%0d, required 0 1 0 0 0 0 0 0",
               dec_valid, fetch_next, decoded_count, dec_pc, dec_imm, dec_class, dec_rd, dec_rs2);
    end
    dec_ready = 1;
    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jump_branch();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
